// File: rtl/ram_loader.sv
`timescale 1ns/1ps
// ram_loader: writes a framed image from the UART byte stream into RAM, holds the 6502 in reset, then hands the bus over.
// Latency: RAM write one cycle after byte acceptance; in RUN the CPU bus reaches RAM combinationally (zero latency).
// Backpressure: rx_ready high while framing (one byte/cycle sustained), low in HOLD/RUN/ERROR. Option: RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [23:0] TIMEOUT   = 24'd0,
    parameter int          RST_HOLD  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dbw,
    input  logic        cpu_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_dbw,
    output logic        ram_we,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        error
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ADDR_LO = 4'd1;
    localparam logic [3:0] S_ADDR_HI = 4'd2;
    localparam logic [3:0] S_LEN_LO  = 4'd3;
    localparam logic [3:0] S_LEN_HI  = 4'd4;
    localparam logic [3:0] S_DATA    = 4'd5;
    localparam logic [3:0] S_CHECK   = 4'd6;
    localparam logic [3:0] S_HOLD    = 4'd7;
    localparam logic [3:0] S_RUN     = 4'd8;
`ifdef RAM_LOADER_CHECKSUM_EN
    localparam logic [3:0] S_ERROR   = 4'd9;
`endif
    localparam logic [3:0] HOLD_INIT = 4'(RST_HOLD - 1);

    logic [3:0]  state_q, state_d;
    logic [23:0] tmo_q, tmo_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] len_q, len_d;
    logic [3:0]  hold_q, hold_d;
    logic        wr_vld_q, wr_vld_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_dat_q, wr_dat_d;
    logic        rx_rdy;
    logic        rx_acc;
    logic        in_run;
    logic [3:0]  after_data;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    assign in_run = (state_q == S_RUN);
    assign rx_rdy = (state_q <= S_CHECK);
    assign rx_acc = rx_valid & rx_rdy;

`ifdef RAM_LOADER_CHECKSUM_EN
    assign after_data = S_CHECK;
`else
    assign after_data = S_HOLD;
`endif

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;
        // Hold counter reloads whenever we are not holding, so every HOLD entry path gets the full count
        hold_d    = (state_q == S_HOLD) ? hold_q : HOLD_INIT;
`ifdef RAM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        if (state_q == S_IDLE) begin
            sum_d = 8'h00;
        end else if (rx_acc && state_q <= S_DATA) begin
            sum_d = sum_q + rx_data;
        end
`endif
        case (state_q)
            S_IDLE: begin
                tmo_d = tmo_q + 24'd1;
                if (rx_acc) begin
                    tmo_d = '0;
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_ADDR_LO;
                    end
                end else if (TIMEOUT != 24'd0 && tmo_d == TIMEOUT) begin
                    state_d = S_HOLD;
                end
            end
            S_ADDR_LO: begin
                if (rx_acc) begin
                    ptr_d[7:0] = rx_data;
                    state_d    = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                if (rx_acc) begin
                    ptr_d[15:8] = rx_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_acc) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_acc) begin
                    len_d   = {rx_data, len_q[7:0]};
                    state_d = ({rx_data, len_q[7:0]} == 16'd0) ? after_data : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_acc) begin
                    wr_vld_d  = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_dat_d  = rx_data;
                    ptr_d     = ptr_q + 16'd1;
                    len_d     = len_q - 16'd1;
                    if (len_q == 16'd1) begin
                        state_d = after_data;
                    end
                end
            end
`ifdef RAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (rx_acc) begin
                    state_d = (8'(sum_q + rx_data) == 8'h00) ? S_HOLD : S_ERROR;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
`endif
            S_HOLD: begin
                if (hold_q == 4'd0) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            ptr_q     <= '0;
            len_q     <= '0;
            hold_q    <= HOLD_INIT;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            hold_q    <= hold_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
`ifdef RAM_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    // The CPU bus only reaches the RAM once running; before that cpu_we is fully masked
    assign ram_we    = in_run ? cpu_we   : wr_vld_q;
    assign ram_addr  = in_run ? cpu_addr : wr_addr_q;
    assign ram_dbw   = in_run ? cpu_dbw  : wr_dat_q;
    assign cpu_rst_n = in_run;
    assign rx_ready  = rx_rdy;
    assign busy      = (state_q >= S_ADDR_LO) && (state_q <= S_CHECK);
`ifdef RAM_LOADER_CHECKSUM_EN
    assign error     = (state_q == S_ERROR);
`else
    assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
`timescale 1ns/1ps
// Directed bench for ram_loader: frame loading, address wrap, timeout auto-run, reset abort, paced input.
module tb_ram_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dbw = 8'h00;
    logic        cpu_we = 1'b0;
    logic [15:0] ram_addr;
    logic [7:0]  ram_dbw;
    logic        ram_we;
    logic        cpu_rst_n;
    logic        busy;
    logic        error;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit mon_en = 1'b1;
    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    int          wc[$];

`ifdef RAM_LOADER_CHECKSUM_EN
    localparam int RISE_GAP = 5;
`else
    localparam int RISE_GAP = 4;
`endif

    ram_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(24'd100), .RST_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cpu_addr(cpu_addr), .cpu_dbw(cpu_dbw), .cpu_we(cpu_we),
        .ram_addr(ram_addr), .ram_dbw(ram_dbw), .ram_we(ram_we),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && ram_we) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_dbw);
            wc.push_back(cyc);
        end
    end

    task do_reset;
        rst_n = 1'b0;
        rx_valid = 1'b0;
        cpu_we = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task send_chk(input logic [7:0] b);
`ifdef RAM_LOADER_CHECKSUM_EN
        send_byte(b);
`else
        if (b == 8'h00) acc_cyc = acc_cyc;
`endif
    endtask

    task wait_run(output int rc);
        rc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cpu_rst_n) begin
                rc = cyc;
                break;
            end
        end
    endtask

    task test_reset;
        rst_n = 1'b0;
        cpu_we = 1'b1;
        cpu_addr = 16'hFFFF;
        cpu_dbw = 8'hEE;
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_ready, ram_we, cpu_rst_n, busy, error} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/we/crst/busy/err=%b want 10000",
                     {rx_ready, ram_we, cpu_rst_n, busy, error});
        end
        checks++;
        if ({ram_addr, ram_dbw} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h dbw=%h want 0000/00", ram_addr, ram_dbw);
        end
        cpu_we = 1'b0;
    endtask

    task test_basic;
        int rc;
        int first;
        do_reset();
        send_byte(8'hA5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_after_sync: got %b want 1", busy);
        end
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h11);
        first = acc_cyc;
        send_byte(8'h22); send_byte(8'h33);
        send_chk(8'h95);
        checks++;
        if ({busy, rx_ready, cpu_rst_n} !== 3'b000) begin
            errors++;
            $display("FAIL basic_hold: got busy/rdy/crst=%b want 000", {busy, rx_ready, cpu_rst_n});
        end
        wait_run(rc);
        checks++;
        if (wa.size() != 3) begin
            errors++;
            $display("FAIL basic_wr_count: got %0d want 3", wa.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa[i] !== 16'h0200 + 16'(i) || wd[i] !== 8'h11 * 8'(i + 1) || wc[i] != first + i) begin
                    errors++;
                    $display("FAIL basic_wr%0d: got %h=%h @%0d want %h=%h @%0d", i, wa[i], wd[i], wc[i],
                             16'h0200 + 16'(i), 8'h11 * 8'(i + 1), first + i);
                end
            end
            checks++;
            if (rc - wc[2] != RISE_GAP) begin
                errors++;
                $display("FAIL basic_rise_gap: got %0d want %0d", rc - wc[2], RISE_GAP);
            end
        end
    endtask

    task test_wrap;
        int rc;
        do_reset();
        send_byte(8'h00); send_byte(8'hFF);
        repeat (2) @(negedge clk);
        checks++;
        if (wa.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL junk: got writes=%0d busy=%b want 0/0", wa.size(), busy);
        end
        send_byte(8'hA5); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        send_chk(8'h9B);
        wait_run(rc);
        checks++;
        if (wa.size() != 2 || rc < 0) begin
            errors++;
            $display("FAIL wrap_count: got writes=%0d run=%0d want 2/run", wa.size(), rc);
        end else begin
            checks++;
            if ({wa[0], wd[0], wa[1], wd[1]} !== 48'hFFFF_AA_0000_BB) begin
                errors++;
                $display("FAIL wrap_data: got %h=%h %h=%h want FFFF=AA 0000=BB", wa[0], wd[0], wa[1], wd[1]);
            end
        end
    endtask

    task test_len_zero;
        int rc;
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h30); send_byte(8'h00); send_byte(8'h00);
        send_chk(8'hD0);
        wait_run(rc);
        checks++;
        if (wa.size() != 0 || rc < 0 || error !== 1'b0) begin
            errors++;
            $display("FAIL len_zero: got writes=%0d run=%0d err=%b want 0/run/0", wa.size(), rc, error);
        end
    endtask

`ifdef RAM_LOADER_CHECKSUM_EN
    task test_checksum;
        int rc;
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h42); send_byte(8'hAD);
        wait_run(rc);
        checks++;
        if (wa.size() != 1 || rc < 0 || error !== 1'b0) begin
            errors++;
            $display("FAIL chk_good: got writes=%0d run=%0d err=%b want 1/run/0", wa.size(), rc, error);
        end else begin
            checks++;
            if ({wa[0], wd[0]} !== 24'h1000_42) begin
                errors++;
                $display("FAIL chk_good_data: got %h=%h want 1000=42", wa[0], wd[0]);
            end
        end
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h42); send_byte(8'hAC);
        repeat (10) @(negedge clk);
        checks++;
        if ({error, cpu_rst_n, rx_ready, busy, ram_we} !== 5'b10000) begin
            errors++;
            $display("FAIL chk_bad: got err/crst/rdy/busy/we=%b want 10000",
                     {error, cpu_rst_n, rx_ready, busy, ram_we});
        end
    endtask
`endif

    task test_reset_mid;
        int rc;
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, cpu_rst_n, rx_ready} !== 3'b001) begin
            errors++;
            $display("FAIL mid_reset: got busy/crst/rdy=%b want 001", {busy, cpu_rst_n, rx_ready});
        end
        checks++;
        if (wa.size() != 2) begin
            errors++;
            $display("FAIL mid_partial: got writes=%0d want 2", wa.size());
        end
        @(negedge clk);
        rst_n = 1'b1;
        wa.delete(); wd.delete(); wc.delete();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h06); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h77);
        send_chk(8'h82);
        wait_run(rc);
        checks++;
        if (wa.size() != 1 || rc < 0) begin
            errors++;
            $display("FAIL mid_fresh: got writes=%0d run=%0d want 1/run", wa.size(), rc);
        end else begin
            checks++;
            if ({wa[0], wd[0]} !== 24'h0600_77) begin
                errors++;
                $display("FAIL mid_fresh_data: got %h=%h want 0600=77", wa[0], wd[0]);
            end
        end
    endtask

    task test_toggle;
        int rc;
        do_reset();
        cpu_addr = 16'hBEEF;
        cpu_dbw = 8'h99;
        cpu_we = 1'b1;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h08); send_byte(8'h04); send_byte(8'h00);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hD1 + 8'(i));
            @(posedge clk);
        end
        send_chk(8'hAA);
        cpu_we = 1'b0;
        wait_run(rc);
        checks++;
        if (wa.size() != 4 || rc < 0) begin
            errors++;
            $display("FAIL toggle_count: got writes=%0d run=%0d want 4/run", wa.size(), rc);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wa[i] !== 16'h0800 + 16'(i) || wd[i] !== 8'hD1 + 8'(i) || (i > 0 && wc[i] - wc[i-1] != 2)) begin
                    errors++;
                    $display("FAIL toggle_wr%0d: got %h=%h @%0d want %h=%h", i, wa[i], wd[i], wc[i],
                             16'h0800 + 16'(i), 8'hD1 + 8'(i));
                end
            end
        end
    endtask

    task test_timeout;
        int n;
        rst_n = 1'b0;
        rx_valid = 1'b0;
        cpu_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (cpu_rst_n) break;
        end
        checks++;
        if (n != 104 || cpu_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL timeout_run: got cycle=%0d crst=%b want 104/1", n, cpu_rst_n);
        end
        mon_en = 1'b0;
        #2;
        cpu_addr = 16'h1234;
        cpu_dbw = 8'h5A;
        cpu_we = 1'b1;
        #1;
        checks++;
        if ({ram_we, ram_addr, ram_dbw} !== 25'h1_1234_5A) begin
            errors++;
            $display("FAIL run_pass: got we=%b addr=%h dbw=%h want 1/1234/5A", ram_we, ram_addr, ram_dbw);
        end
        cpu_we = 1'b0;
        #1;
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL run_pass_we0: got %b want 0", ram_we);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_len_zero();
`ifdef RAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        test_toggle();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
